// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter_if
// Brief   : Request/grant bus for the IO and processor sides plus the shared
//           BRAM port, as seen by bram_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_gnt;
    logic          io_rvalid;

    logic          pro_req;
    logic          pro_we;
    logic [AW-1:0] pro_addr;
    logic [DW-1:0] pro_wdata;
    logic          pro_gnt;
    logic          pro_rvalid;
    logic          pro_stall;

    logic          io_lock;
    logic          busy;
    logic [DW-1:0] mem_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Arbiter view: it owns the BRAM port and answers both requesters
    modport master (
        input  io_req, io_we, io_addr, io_wdata,
        input  pro_req, pro_we, pro_addr, pro_wdata,
        input  io_lock, mem_dout,
        output io_gnt, io_rvalid, pro_gnt, pro_rvalid, pro_stall,
        output busy, mem_rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        output io_req, io_we, io_addr, io_wdata,
        output pro_req, pro_we, pro_addr, pro_wdata,
        output io_lock, mem_dout,
        input  io_gnt, io_rvalid, pro_gnt, pro_rvalid, pro_stall,
        input  busy, mem_rdata, mem_en, mem_we, mem_addr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter
// Brief   : Round-robin, burst-limited sharing of one BRAM port between the
//           UART IO block and the processor, with read-data return tagging.
// Revision: 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input wire                   clk_10,
    input wire                   rst_n,
    bram_port_arbiter_if.master  bus
);

    localparam int C_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(MAX_BURST);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IO   = 2'd1,
        OWN_PRO  = 2'd2
    } owner_t;

    owner_t              r_owner;
    logic [C_CNT_W-1:0]  r_cnt;
    logic                r_rr_last_pro;
    logic [AW-1:0]       r_addr_hold;
    logic [DW-1:0]       r_din_hold;
    logic [RD_LAT-1:0]   r_tag_v;
    logic [RD_LAT-1:0]   r_tag_pro;

    logic                w_io_elig;
    logic                w_pro_elig;
    logic                w_io_gnt;
    logic                w_pro_gnt;
    logic                w_cur_gnt;
    logic                w_cur_req;
    logic                w_oth_elig;
    owner_t              w_oth;
    logic [C_CNT_W-1:0]  w_cnt_inc;
    logic                w_burst_done;
    logic                w_rd;

    assign w_io_elig  = bus.io_req;
    assign w_pro_elig = bus.pro_req & ~bus.io_lock;
    assign w_io_gnt   = (r_owner == OWN_IO)  & bus.io_req;
    assign w_pro_gnt  = (r_owner == OWN_PRO) & w_pro_elig;
    assign w_cur_gnt  = w_io_gnt | w_pro_gnt;
    assign w_cur_req  = (r_owner == OWN_IO) ? w_io_elig  : w_pro_elig;
    assign w_oth_elig = (r_owner == OWN_IO) ? w_pro_elig : w_io_elig;
    assign w_oth      = (r_owner == OWN_IO) ? OWN_PRO    : OWN_IO;

    // Saturating count: an uncontested owner may run indefinitely, and a
    // late-arriving competitor must still see the limit as reached.
    assign w_cnt_inc    = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;
    assign w_burst_done = (w_cnt_inc == C_CNT_MAX);

    assign w_rd = (w_io_gnt & ~bus.io_we) | (w_pro_gnt & ~bus.pro_we);

    always_ff @(posedge clk_10) begin
        if (!rst_n) begin
            r_owner       <= OWN_NONE;
            r_cnt         <= '0;
            r_rr_last_pro <= 1'b1;
            r_addr_hold   <= '0;
            r_din_hold    <= '0;
            r_tag_v       <= '0;
            r_tag_pro     <= '0;
        end else begin
            case (r_owner)
                OWN_NONE: begin
                    r_cnt <= '0;
                    if (w_io_elig && w_pro_elig)
                        r_owner <= r_rr_last_pro ? OWN_IO : OWN_PRO;
                    else if (w_io_elig)
                        r_owner <= OWN_IO;
                    else if (w_pro_elig)
                        r_owner <= OWN_PRO;
                end
                OWN_IO, OWN_PRO: begin
                    if (w_cur_gnt) begin
                        r_rr_last_pro <= (r_owner == OWN_PRO);
                        if (w_oth_elig && (w_burst_done || !w_cur_req)) begin
                            r_owner <= w_oth;
                            r_cnt   <= '0;
                        end else if (!w_cur_req) begin
                            r_owner <= OWN_NONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_owner <= w_oth_elig ? w_oth : OWN_NONE;
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_cnt   <= '0;
                end
            endcase

            if (w_io_gnt) begin
                r_addr_hold <= bus.io_addr;
                r_din_hold  <= bus.io_wdata;
            end else if (w_pro_gnt) begin
                r_addr_hold <= bus.pro_addr;
                r_din_hold  <= bus.pro_wdata;
            end

            r_tag_v[0]   <= w_rd;
            r_tag_pro[0] <= w_pro_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_pro[i] <= r_tag_pro[i-1];
            end
        end
    end

    assign bus.io_gnt     = w_io_gnt;
    assign bus.pro_gnt    = w_pro_gnt;
    assign bus.pro_stall  = bus.pro_req & ~w_pro_gnt;
    assign bus.io_rvalid  = r_tag_v[RD_LAT-1] & ~r_tag_pro[RD_LAT-1];
    assign bus.pro_rvalid = r_tag_v[RD_LAT-1] &  r_tag_pro[RD_LAT-1];
    assign bus.mem_rdata  = bus.mem_dout;
    assign bus.busy       = (r_owner != OWN_NONE) | (|r_tag_v);

    assign bus.mem_en   = w_cur_gnt;
    assign bus.mem_we   = w_io_gnt ? bus.io_we    : (w_pro_gnt ? bus.pro_we    : 1'b0);
    assign bus.mem_addr = w_io_gnt ? bus.io_addr  : (w_pro_gnt ? bus.pro_addr  : r_addr_hold);
    assign bus.mem_din  = w_io_gnt ? bus.io_wdata : (w_pro_gnt ? bus.pro_wdata : r_din_hold);

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_port_arbiter
// Brief   : Directed self-checking bench; u_dut1 uses RD_LAT=1, u_dut2 RD_LAT=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.AW(16), .DW(16)) u_if1 ();
    bram_port_arbiter_if #(.AW(16), .DW(16)) u_if2 ();

    bram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_BURST(8)) u_dut1 (
        .clk_10 (clk),
        .rst_n  (rst_n),
        .bus    (u_if1)
    );

    bram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .MAX_BURST(8)) u_dut2 (
        .clk_10 (clk),
        .rst_n  (rst_n),
        .bus    (u_if2)
    );

    // BRAM models: latency 1 for u_dut1, latency 2 for u_dut2
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];
    logic [15:0] r_d1, r_d2a, r_d2b;

    always @(posedge clk) begin
        if (u_if1.mem_en) begin
            if (u_if1.mem_we) mem1[u_if1.mem_addr[7:0]] <= u_if1.mem_din;
            else              r_d1 <= mem1[u_if1.mem_addr[7:0]];
        end
        if (u_if2.mem_en && !u_if2.mem_we) r_d2a <= mem2[u_if2.mem_addr[7:0]];
        r_d2b <= r_d2a;
    end

    assign u_if1.mem_dout = r_d1;
    assign u_if2.mem_dout = r_d2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  found, idx, gprev, ng, nrv, fg, lg, frv;
        logic prev_io;

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem2[i] = 16'hA000 + 16'(i * 7);
        end
        mem1[8'h10] = 16'hBEEF;
        mem1[8'h20] = 16'h2020;
        mem1[8'h30] = 16'h3030;
        r_d1 = '0; r_d2a = '0; r_d2b = '0;

        u_if1.io_req = 0; u_if1.io_we = 0; u_if1.io_addr = '0; u_if1.io_wdata = '0;
        u_if1.pro_req = 0; u_if1.pro_we = 0; u_if1.pro_addr = '0; u_if1.pro_wdata = '0;
        u_if1.io_lock = 0;
        u_if2.io_req = 0; u_if2.io_we = 0; u_if2.io_addr = '0; u_if2.io_wdata = '0;
        u_if2.pro_req = 0; u_if2.pro_we = 0; u_if2.pro_addr = '0; u_if2.pro_wdata = '0;
        u_if2.io_lock = 0;

        // ---- reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_io_gnt",     u_if1.io_gnt, 0);
        chk("rst_pro_gnt",    u_if1.pro_gnt, 0);
        chk("rst_io_rvalid",  u_if1.io_rvalid, 0);
        chk("rst_pro_rvalid", u_if1.pro_rvalid, 0);
        chk("rst_mem_en",     u_if1.mem_en, 0);
        chk("rst_mem_we",     u_if1.mem_we, 0);
        chk("rst_mem_addr",   u_if1.mem_addr, 0);
        chk("rst_mem_din",    u_if1.mem_din, 0);
        chk("rst_busy",       u_if1.busy, 0);
        chk("rst_busy2",      u_if2.busy, 0);
        rst_n = 1;

        // ---- test 1: single PRO read from idle
        @(negedge clk);
        u_if1.pro_req = 1; u_if1.pro_we = 0; u_if1.pro_addr = 16'h0010;
        #1;
        chk("t1_c0_pro_gnt",   u_if1.pro_gnt, 0);
        chk("t1_c0_pro_stall", u_if1.pro_stall, 1);
        @(negedge clk); #1;
        chk("t1_c1_pro_gnt",   u_if1.pro_gnt, 1);
        chk("t1_c1_pro_stall", u_if1.pro_stall, 0);
        chk("t1_c1_mem_en",    u_if1.mem_en, 1);
        chk("t1_c1_mem_addr",  u_if1.mem_addr, 16'h0010);
        chk("t1_c1_rvalid",    u_if1.pro_rvalid, 0);
        @(negedge clk);
        u_if1.pro_req = 0;
        #1;
        chk("t1_c2_pro_rvalid", u_if1.pro_rvalid, 1);
        chk("t1_c2_io_rvalid",  u_if1.io_rvalid, 0);
        chk("t1_c2_rdata",      u_if1.mem_rdata, 16'hBEEF);
        chk("t1_c2_pro_stall",  u_if1.pro_stall, 0);
        @(negedge clk); #1;
        chk("t1_c3_busy",       u_if1.busy, 0);
        chk("t1_c3_pro_rvalid", u_if1.pro_rvalid, 0);

        // ---- test 2: both requesting continuously, 8/8 alternation
        @(negedge clk);
        u_if1.io_req = 1;  u_if1.io_we = 0;  u_if1.io_addr = 16'h0020;
        u_if1.pro_req = 1; u_if1.pro_we = 0; u_if1.pro_addr = 16'h0030;
        #1;
        chk("t2_c0_mem_en", u_if1.mem_en, 0);
        prev_io = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            chk("t2_io_gnt",  u_if1.io_gnt,  (i < 8) ? 1 : 0);
            chk("t2_pro_gnt", u_if1.pro_gnt, (i < 8) ? 0 : 1);
            chk("t2_mem_en",  u_if1.mem_en, 1);
            if (i > 0) begin
                chk("t2_io_rvalid",  u_if1.io_rvalid,  prev_io ? 1 : 0);
                chk("t2_pro_rvalid", u_if1.pro_rvalid, prev_io ? 0 : 1);
                chk("t2_rdata",      u_if1.mem_rdata,  prev_io ? 16'h2020 : 16'h3030);
            end
            prev_io = (i < 8);
        end
        @(negedge clk);
        u_if1.io_req = 0; u_if1.pro_req = 0;
        #1;
        chk("t2_last_pro_rvalid", u_if1.pro_rvalid, 1);
        repeat (2) @(negedge clk);

        // ---- test 3: io_lock starves PRO, release lets it in
        u_if1.io_lock = 1; u_if1.io_req = 1; u_if1.pro_req = 1;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("t3_pro_gnt",   u_if1.pro_gnt, 0);
            chk("t3_pro_stall", u_if1.pro_stall, 1);
            if (i > 0) chk("t3_io_gnt", u_if1.io_gnt, 1);
            @(negedge clk);
        end
        u_if1.io_lock = 0;
        found = 0;
        for (int k = 0; k < 9 && found == 0; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (u_if1.pro_gnt) found = 1;
        end
        chk("t3_pro_gnt_after_unlock", found, 1);
        @(negedge clk);
        u_if1.io_req = 0; u_if1.pro_req = 0;
        repeat (2) @(negedge clk);

        // ---- test 4: IO write then PRO read of the same word
        u_if1.io_req = 1; u_if1.io_we = 1; u_if1.io_addr = 16'h0005; u_if1.io_wdata = 16'h1234;
        u_if1.pro_req = 1; u_if1.pro_we = 0; u_if1.pro_addr = 16'h0005;
        #1;
        chk("t4_c0_io_gnt", u_if1.io_gnt, 0);
        @(negedge clk); #1;
        chk("t4_c1_io_gnt",   u_if1.io_gnt, 1);
        chk("t4_c1_mem_we",   u_if1.mem_we, 1);
        chk("t4_c1_mem_addr", u_if1.mem_addr, 16'h0005);
        chk("t4_c1_mem_din",  u_if1.mem_din, 16'h1234);
        @(negedge clk);
        u_if1.io_req = 0;
        #1;
        chk("t4_c2_mem_en",    u_if1.mem_en, 0);
        chk("t4_c2_mem_we",    u_if1.mem_we, 0);
        chk("t4_c2_addr_hold", u_if1.mem_addr, 16'h0005);
        chk("t4_c2_din_hold",  u_if1.mem_din, 16'h1234);
        chk("t4_c2_io_rvalid", u_if1.io_rvalid, 0);
        @(negedge clk); #1;
        chk("t4_c3_pro_gnt", u_if1.pro_gnt, 1);
        chk("t4_c3_mem_we",  u_if1.mem_we, 0);
        @(negedge clk);
        u_if1.pro_req = 0;
        #1;
        chk("t4_c4_pro_rvalid", u_if1.pro_rvalid, 1);
        chk("t4_c4_io_rvalid",  u_if1.io_rvalid, 0);
        chk("t4_c4_rdata",      u_if1.mem_rdata, 16'h1234);
        repeat (2) @(negedge clk);

        // ---- test 5: reset mid PRO burst with a read in flight
        u_if1.pro_req = 1; u_if1.pro_we = 0; u_if1.pro_addr = 16'h0010; u_if1.pro_wdata = 16'h5555;
        @(negedge clk); #1;
        chk("t5_pre_pro_gnt", u_if1.pro_gnt, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        u_if1.io_req = 1; u_if1.io_we = 0; u_if1.io_addr = 16'h0020;
        #1;
        chk("t5_pro_rvalid", u_if1.pro_rvalid, 0);
        chk("t5_io_rvalid",  u_if1.io_rvalid, 0);
        chk("t5_busy",       u_if1.busy, 0);
        chk("t5_mem_addr",   u_if1.mem_addr, 0);
        chk("t5_mem_din",    u_if1.mem_din, 0);
        chk("t5_io_gnt0",    u_if1.io_gnt, 0);
        chk("t5_pro_gnt0",   u_if1.pro_gnt, 0);
        @(negedge clk); #1;
        chk("t5_first_io_gnt",  u_if1.io_gnt, 1);
        chk("t5_first_pro_gnt", u_if1.pro_gnt, 0);
        chk("t5_pro_rvalid2",   u_if1.pro_rvalid, 0);
        @(negedge clk);
        u_if1.io_req = 0; u_if1.pro_req = 0;
        repeat (2) @(negedge clk);

        // ---- test 6: 100 back-to-back PRO reads, RD_LAT=2
        idx = 0; gprev = 0; ng = 0; nrv = 0; fg = -1; lg = -1; frv = -1;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (gprev != 0) idx++;
            u_if2.pro_req  = (idx < 100);
            u_if2.pro_addr = 16'(idx);
            #1;
            gprev = u_if2.pro_gnt ? 1 : 0;
            if (gprev != 0) begin
                if (fg < 0) fg = c;
                lg = c;
                ng++;
            end
            if (u_if2.pro_rvalid) begin
                if (frv < 0) frv = c;
                chk("t6_rdata", u_if2.mem_rdata, 16'hA000 + 16'(nrv * 7));
                nrv++;
            end
        end
        chk("t6_grants",       ng, 100);
        chk("t6_rvalids",      nrv, 100);
        chk("t6_no_break",     lg - fg, 99);
        chk("t6_first_rv_lat", frv - fg, 2);
        chk("t6_idle_busy",    u_if2.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
